// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM-port arbiter: FSM/request encodings, RAM handshake states
// and the latched transaction payload.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} req_kind_t;

  localparam logic [WORD_W-1:0] ARB_BADDATA = 32'hBAD1BAD1;

  typedef struct packed {
    req_kind_t         kind;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] store;
  } arb_txn_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NCORES.
module rr_picker #(
  parameter int unsigned NCORES = 2,
  parameter int unsigned IW     = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic              valid,
  output logic [IW-1:0]     idx
);

  logic [IW-1:0] pos;

  // Scan from farthest to nearest so the candidate closest to ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = int'(NCORES) - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr) + k) % int'(NCORES));
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises per-core instruction/data requests onto a single RAM port, one
// transaction at a time, with a one-cycle wait=0 completion pulse per request.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NCORES  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NCORES-1:0]              iREN,
  input  logic [NCORES-1:0][WORD_W-1:0]  iaddr,
  output logic [NCORES-1:0]              iwait,
  output logic [NCORES-1:0][WORD_W-1:0]  iload,
  input  logic [NCORES-1:0]              dREN,
  input  logic [NCORES-1:0]              dWEN,
  input  logic [NCORES-1:0][WORD_W-1:0]  daddr,
  input  logic [NCORES-1:0][WORD_W-1:0]  dstore,
  output logic [NCORES-1:0]              dwait,
  output logic [NCORES-1:0][WORD_W-1:0]  dload,
  output logic                           ramREN,
  output logic                           ramWEN,
  output logic [WORD_W-1:0]              ramaddr,
  output logic [WORD_W-1:0]              ramstore,
  input  logic [WORD_W-1:0]              ramload,
  input  ramstate_t                      ramstate,
  output logic                           timeout
);

  localparam int unsigned IW = $clog2(NCORES);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_t        state, state_n;
  arb_txn_t          txn, txn_n;
  logic [IW-1:0]     core, core_n;
  logic [IW-1:0]     rr_ptr;
  logic [TW-1:0]     tcnt;

  logic [NCORES-1:0] d_req;
  logic              d_valid, i_valid;
  logic [IW-1:0]     d_idx, i_idx;

  logic              done_c;
  logic [WORD_W-1:0] rdata_c;
  logic              ram_ren_d, ram_wen_d, timeout_d;
  logic [NCORES-1:0] iwait_d, dwait_d;

  assign d_req = dREN | dWEN;

  rr_picker #(.NCORES(NCORES), .IW(IW)) u_dpick (
    .req(d_req), .ptr(rr_ptr), .valid(d_valid), .idx(d_idx)
  );

  rr_picker #(.NCORES(NCORES), .IW(IW)) u_ipick (
    .req(iREN), .ptr(rr_ptr), .valid(i_valid), .idx(i_idx)
  );

  // State, latched transaction, round-robin pointer and BUSY-cycle counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      txn    <= '0;
      core   <= '0;
      rr_ptr <= '0;
      tcnt   <= '0;
    end else begin
      state <= state_n;
      txn   <= txn_n;
      core  <= core_n;
      tcnt  <= (state == BUSY) ? tcnt + TW'(1) : '0;
      if (state == RESP)
        rr_ptr <= (core == IW'(NCORES - 1)) ? '0 : core + IW'(1);
    end
  end

  // Next state; the winner's address and store data are captured only when leaving IDLE.
  always_comb begin
    state_n = state;
    txn_n   = txn;
    core_n  = core;
    case (state)
      IDLE: begin
        if (d_valid) begin
          state_n     = BUSY;
          core_n      = d_idx;
          txn_n.kind  = dWEN[d_idx] ? DWRITE : DREAD;
          txn_n.addr  = daddr[d_idx];
          txn_n.store = dstore[d_idx];
        end else if (i_valid) begin
          state_n     = BUSY;
          core_n      = i_idx;
          txn_n.kind  = IFETCH;
          txn_n.addr  = iaddr[i_idx];
          txn_n.store = '0;
        end
      end
      BUSY: begin
        if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR || tcnt == TW'(TIMEOUT))
          state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next-cycle output values, derived from the upcoming state so every output is a flop.
  always_comb begin
    done_c    = (state == BUSY) && (state_n == RESP);
    rdata_c   = (ramstate == RAM_ACCESS) ? ramload : ARB_BADDATA;
    ram_ren_d = (state_n == BUSY) && (txn_n.kind != DWRITE);
    ram_wen_d = (state_n == BUSY) && (txn_n.kind == DWRITE);
    timeout_d = done_c && (ramstate != RAM_ACCESS) && (ramstate != RAM_ERROR);
    iwait_d   = '1;
    dwait_d   = '1;
    if (state_n == RESP) begin
      if (txn_n.kind == IFETCH) iwait_d[core_n] = 1'b0;
      else                      dwait_d[core_n] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ramREN  <= 1'b0;
      ramWEN  <= 1'b0;
      timeout <= 1'b0;
      iwait   <= '1;
      dwait   <= '1;
      iload   <= '0;
      dload   <= '0;
    end else begin
      ramREN  <= ram_ren_d;
      ramWEN  <= ram_wen_d;
      timeout <= timeout_d;
      iwait   <= iwait_d;
      dwait   <= dwait_d;
      if (done_c) begin
        if (txn.kind == IFETCH) iload[core] <= rdata_c;
        else                    dload[core] <= rdata_c;
      end
    end
  end

  assign ramaddr  = txn.addr;
  assign ramstore = txn.store;

endmodule
